// File: rtl/bin2bcd_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd_seq_pkg                                                      |
// | Shared widths and FSM encoding for the sequential binary-to-BCD path.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package bin2bcd_seq_pkg;

  localparam int BIN_W_DEF = 20;
  localparam int DIG_N_DEF = 7;

  // Packed-BCD word width; the display driver sizes its input from this.
  localparam int BCD_W = 4 * DIG_N_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_digit_adj                                                        |
// | Per-nibble add-3 correction applied before each double-dabble shift. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bin2bcd_seq                                                          |
// | Shift-and-add-3 converter, one input bit per clock, held BCD result. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF,
  parameter int DIG_N = DIG_N_DEF
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [BIN_W-1:0]   din,
  input  logic               din_vld,
  output logic               busy,
  output logic [4*DIG_N-1:0] bcd,
  output logic               dout_vld
);

  localparam int ACC_W = 4 * DIG_N;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_e             state_q;
  logic [BIN_W-1:0]   sr_q;
  logic [BIN_W-1:0]   sr_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               vld_q;
  logic [ACC_W-1:0]   bcd_q;

  for (genvar i = 0; i < DIG_N; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (acc_q[4*i +: 4]),
      .nib_o (acc_adj[4*i +: 4])
    );
  end

  // Adjusted accumulator and shift register move left as one long word.
  assign acc_d = {acc_adj[ACC_W-2:0], sr_q[BIN_W-1]};
  assign sr_d  = {sr_q[BIN_W-2:0], 1'b0};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      bcd_q   <= '0;
    end else begin
      vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (din_vld) begin
            sr_q    <= din;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          bcd_q   <= acc_q;
          vld_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign bcd      = bcd_q;
  assign dout_vld = vld_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_bin2bcd_seq                                                       |
// | Directed table, corner sequences and random sweep vs decimal model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_bin2bcd_seq;

  logic        sys_clk;
  logic        sys_rst;
  logic [19:0] din;
  logic        din_vld;
  logic        busy;
  logic [27:0] bcd;
  logic        dout_vld;

  int compared = 0;
  int failed   = 0;
  int vld_count = 0;

  bin2bcd_seq #(.BIN_W(20), .DIG_N(7)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .din      (din),
    .din_vld  (din_vld),
    .busy     (busy),
    .bcd      (bcd),
    .dout_vld (dout_vld)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [19:0] din;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs [10];

  // Reference: plain decimal digit extraction.
  function automatic logic [27:0] ref_bcd(input int unsigned v);
    logic [27:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 7; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Steps until dout_vld is seen; lat is the number of edges taken.
  task automatic wait_result(output int lat);
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      lat++;
      if (dout_vld === 1'b1) return;
    end
    failed++;
    compared++;
    $display("FAIL wait_result: got timeout after %0d edges, expected dout_vld", lat);
    lat = -1;
  endtask

  task automatic do_conv(input logic [19:0] v, input logic [27:0] exp);
    int lat;
    din     = v;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_result(lat);
    chk("latency", 32'(lat), 32'd21);
    chk("bcd", 32'(bcd), 32'(exp));
    chk("busy_at_result", 32'(busy), 32'd0);
    step();
    chk("dout_vld_one_cycle", 32'(dout_vld), 32'd0);
  endtask

  // bcd must not change except on a dout_vld cycle or after a reset edge.
  logic [27:0] prev_bcd;
  bit          rst_pend = 1'b1;
  always @(negedge sys_clk) begin
    if (dout_vld === 1'b1) vld_count++;
    if (rst_pend || dout_vld === 1'b1) begin
      prev_bcd = bcd;
    end else begin
      compared++;
      if (bcd !== prev_bcd) begin
        failed++;
        $display("FAIL bcd_hold: got %h, expected %h", bcd, prev_bcd);
      end
    end
    rst_pend = (sys_rst !== 1'b0);
  end

  initial begin
    int lat;
    int base;
    logic [19:0] rv;

    vecs[0] = '{20'd0,       28'h0000000};
    vecs[1] = '{20'hFFFFF,   28'h1048575};
    vecs[2] = '{20'd9999,    28'h0009999};
    vecs[3] = '{20'd12345,   28'h0012345};
    vecs[4] = '{20'd678,     28'h0000678};
    vecs[5] = '{20'd7,       28'h0000007};
    vecs[6] = '{20'd1,       28'h0000001};
    vecs[7] = '{20'd10,      28'h0000010};
    vecs[8] = '{20'd99999,   28'h0099999};
    vecs[9] = '{20'd524288,  28'h0524288};

    sys_rst = 1'b1;
    din     = '0;
    din_vld = 1'b0;
    step();
    step();
    sys_rst = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_dout_vld", 32'(dout_vld), 32'd0);
    step();

    for (int i = 0; i < 10; i++) begin
      do_conv(vecs[i].din, vecs[i].exp);
    end

    // Start requests during a conversion are dropped, not queued.
    base    = vld_count;
    din     = 20'd9999;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    step();
    step();
    din     = 20'd5;
    din_vld = 1'b1;
    for (int c = 0; c < 8; c++) step();
    din_vld = 1'b0;
    wait_result(lat);
    chk("ignored_latency", 32'(lat), 32'd11);
    chk("ignored_bcd", 32'(bcd), 32'h0009999);
    for (int c = 0; c < 30; c++) step();
    chk("ignored_pulses", 32'(vld_count - base), 32'd1);

    // din_vld held high: second accept right after returning to IDLE.
    din     = 20'd12345;
    din_vld = 1'b1;
    step();
    din     = 20'd678;
    wait_result(lat);
    chk("b2b_lat1", 32'(lat), 32'd21);
    chk("b2b_bcd1", 32'(bcd), 32'h0012345);
    wait_result(lat);
    chk("b2b_spacing", 32'(lat), 32'd22);
    chk("b2b_bcd2", 32'(bcd), 32'h0000678);
    din_vld = 1'b0;
    step();
    chk("b2b_idle_after", 32'(busy), 32'd0);

    // Reset on the same edge as a start request wins.
    din     = 20'd3;
    din_vld = 1'b1;
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    din_vld = 1'b0;
    chk("rst_wins_busy", 32'(busy), 32'd0);
    chk("rst_wins_bcd", 32'(bcd), 32'd0);
    step();
    chk("rst_wins_busy2", 32'(busy), 32'd0);

    // Reset mid-conversion aborts with no result pulse.
    do_conv(20'd42, 28'h0000042);
    din     = 20'd54321;
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    for (int c = 0; c < 9; c++) step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'd0);
    chk("midrst_vld", 32'(dout_vld), 32'd0);
    base = vld_count;
    for (int c = 0; c < 30; c++) step();
    chk("midrst_no_pulse", 32'(vld_count - base), 32'd0);
    do_conv(20'd7, 28'h0000007);

    // Random sweep against the decimal model.
    void'($urandom(32'd20240611));
    for (int n = 0; n < 1000; n++) begin
      rv = 20'($urandom_range(0, 20'hFFFFF));
      do_conv(rv, ref_bcd(32'(rv)));
      if ($urandom_range(0, 3) == 0) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) placed directly downstream of the 20-bit moving-average filter. It converts the filtered humidity/temperature word into packed decimal digits for the display driver. It samples a 20-bit value on a start strobe, runs a fixed-length conversion, then presents the packed BCD result with a one-cycle valid pulse. The result is held stable until the next conversion completes.

## Interface
- BIN_W, 20: binary input width.
- DIG_N, 7: number of BCD digits; must satisfy 10^DIG_N > 2^BIN_W − 1 (7 digits cover 1 048 575).
- sys_clk  in  1  single clock; all logic on its rising edge.
- sys_rst  in  1  reset, synchronous and active-high.
- din  in  BIN_W  binary value; sampled only when a start is accepted.
- din_vld  in  1  start request; accepted on an edge where din_vld=1 and busy=0.
- busy  out  1  high from the accept edge until the return to IDLE.
- bcd  out  4*DIG_N  packed BCD, digit 0 (units) in bits [3:0]; holds the last completed result.
- dout_vld  out  1  one-cycle pulse; bcd is new and valid in that cycle.

## Operation
- FSM states are IDLE, SHIFT and DONE. busy=1 in SHIFT and DONE.
- **IDLE**: on accept, load shift register with din, clear the BCD accumulator (4*DIG_N bits), clear iteration counter cnt, and go to SHIFT. din_vld=0 stays in IDLE.
- **SHIFT**: each cycle does the following, in order:
  - Every accumulator nibble ≥5 gets +3 (4-bit, no carry between nibbles).
  - Shift {accumulator, shift register} left by 1; the MSB of the shift register enters accumulator bit 0.
  - cnt increments.
  - When cnt == BIN_W−1 in the current cycle, go to DONE. SHIFT lasts exactly BIN_W cycles.
- **DONE**: bcd <= accumulator, dout_vld <= 1, go to IDLE.
- din_vld while busy=1 is ignored, not queued; din changes during a conversion have no effect.
- cnt width is clog2(BIN_W). All adjust arithmetic is 4-bit per nibble; no accumulator overflow is possible under the DIG_N constraint.
- Reset (any state, including mid-conversion): state=IDLE, busy=0, dout_vld=0, bcd=0, accumulator/shift register/cnt=0. A conversion interrupted by reset produces no dout_vld.

## Timing
- Accept at edge k.
- busy=1 after edge k.
- SHIFT iterations occur on edges k+1 … k+BIN_W.
- DONE is entered after edge k+BIN_W. The bcd update and dout_vld=1 are registered at edge k+BIN_W+1, i.e. visible in the cycle after it.
- busy=0 after edge k+BIN_W+1, simultaneously with dout_vld=1. A new start may be accepted at edge k+BIN_W+2.
- Latency, accept edge to result edge: BIN_W+1 = 21 cycles. Minimum start-to-start spacing: BIN_W+2 = 22 cycles.
- dout_vld deasserts on the following edge.
- din_vld held high continuously: the next start is accepted at edge k+BIN_W+2, after the return to IDLE.
- Reset asserted on the same edge as an accept: reset wins.

## Structure
- Shared package holds:
  - BIN_W and DIG_N defaults.
  - State encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - A localparam for the packed-BCD width (4*DIG_N), reused by the display driver.
- One sub-module: bcd_digit_adj. Purely combinational: 4-bit in, 4-bit out, outputs in+3 when in ≥5, else in. It is instantiated DIG_N times via generate.

## Test plan
- **Zero**: reset, din=0 with a start pulse → after 21 cycles dout_vld pulses once, bcd=28'h0000000, busy low in the same cycle.
- **Full scale**: din=20'hFFFFF (1 048 575) → bcd=28'h1048575, dout_vld exactly 21 edges after the accept edge.
- **Ignored start**: din=9999 accepted, then din_vld=1 with din=5 on cycles 3–10 → single result bcd=28'h0009999, no second dout_vld until a later idle start.
- **Back-to-back**: din_vld held high with din=12345 then 678 → results 28'h0012345 then 28'h0000678, dout_vld pulses 22 cycles apart.
- **Mid-operation reset**: start with din=54321, assert sys_rst at cycle 10 → busy=0, bcd=0, no dout_vld. A new start with din=7 then yields 28'h0000007 after 21 cycles.
- **Random sweep (directed seeds)**: 1000 values in 0…1 048 575 → each bcd matches a reference decimal conversion, and bcd stays unchanged between dout_vld pulses.
